// File: rtl/turbosound_pkg.sv
// Shared definitions for the TurboSound stereo mixer and its 1-bit DAC stage.
package turbosound_pkg;

  // Width of the mixed sample; 2 x 3 x 255 = 1530 fits without overflow.
  localparam int MIX_W = 11;

  // Stereo placement of the three channels of each PSG; code 3 behaves as mono.
  localparam logic [1:0] MODE_ABC  = 2'd0;
  localparam logic [1:0] MODE_ACB  = 2'd1;
  localparam logic [1:0] MODE_MONO = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } mix_state_t;

endpackage

// File: rtl/turbosound_mixer_sigma_delta.sv
// First-order sigma-delta modulator: the carry out of an 11-bit phase
// accumulator forms the bitstream, so its density equals din / 2048.
module sigma_delta_dac
  import turbosound_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [MIX_W-1:0] din,
  output logic             dout
);

  logic [MIX_W:0] acc;

  // Drop the previous carry and add the new sample; the fresh carry is the output bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= {1'b0, acc[MIX_W-1:0]} + {1'b0, din};
    end
  end

  assign dout = acc[MIX_W];

endmodule

// File: rtl/turbosound_mixer.sv
// Stereo mixer for the dual-AY TurboSound: snapshots six channel levels on a
// strobe, accumulates one channel per clock into left/right sums according to
// the stereo mode, then feeds the registered sums to two sigma-delta DACs.
module turbosound_mixer
  import turbosound_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             strobe,
  input  logic [1:0]       mode,
  input  logic [7:0]       a1,
  input  logic [7:0]       b1,
  input  logic [7:0]       c1,
  input  logic [7:0]       a2,
  input  logic [7:0]       b2,
  input  logic [7:0]       c2,
  output logic             busy,
  output logic             valid,
  output logic [MIX_W-1:0] left,
  output logic [MIX_W-1:0] right,
  output logic             dac_l,
  output logic             dac_r
);

  mix_state_t       state, next_state;
  logic [7:0]       snap [6];
  logic [1:0]       mode_q;
  logic [2:0]       idx;
  logic [MIX_W-1:0] acc_l, acc_r;
  logic [MIX_W-1:0] add_l, add_r;
  logic [MIX_W-1:0] single, double;
  logic [7:0]       cur;
  logic [1:0]       pos;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: a strobe is only honoured in IDLE, so no request is ever queued.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (strobe) next_state = ACC;
      ACC:     if (idx == 3'd5) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pick the snapshot channel for this step and its position within its chip (0=A, 1=B, 2=C).
  always_comb begin
    cur = '0;
    pos = 2'd0;
    case (idx)
      3'd0: begin cur = snap[0]; pos = 2'd0; end
      3'd1: begin cur = snap[1]; pos = 2'd1; end
      3'd2: begin cur = snap[2]; pos = 2'd2; end
      3'd3: begin cur = snap[3]; pos = 2'd0; end
      3'd4: begin cur = snap[4]; pos = 2'd1; end
      3'd5: begin cur = snap[5]; pos = 2'd2; end
      default: begin cur = '0; pos = 2'd0; end
    endcase
  end

  assign single = {3'b000, cur};
  assign double = {2'b00, cur, 1'b0};

  // Stereo weighting: the hard-panned channel counts double, the centre one goes to both sides.
  always_comb begin
    add_l = '0;
    add_r = '0;
    case (mode_q)
      MODE_ABC: begin
        case (pos)
          2'd0:    add_l = double;
          2'd1:    begin add_l = single; add_r = single; end
          2'd2:    add_r = double;
          default: ;
        endcase
      end
      MODE_ACB: begin
        case (pos)
          2'd0:    add_l = double;
          2'd1:    add_r = double;
          2'd2:    begin add_l = single; add_r = single; end
          default: ;
        endcase
      end
      default: begin
        add_l = single;
        add_r = single;
      end
    endcase
  end

  // Datapath: snapshot on accept, accumulate one channel per ACC cycle, publish in DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) snap[i] <= '0;
      mode_q <= MODE_ABC;
      idx    <= '0;
      acc_l  <= '0;
      acc_r  <= '0;
      left   <= '0;
      right  <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            snap[0] <= a1;
            snap[1] <= b1;
            snap[2] <= c1;
            snap[3] <= a2;
            snap[4] <= b2;
            snap[5] <= c2;
            mode_q  <= mode;
            idx     <= '0;
            acc_l   <= '0;
            acc_r   <= '0;
          end
        end
        ACC: begin
          acc_l <= acc_l + add_l;
          acc_r <= acc_r + add_r;
          idx   <= idx + 3'd1;
        end
        DONE: begin
          left  <= acc_l;
          right <= acc_r;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

  sigma_delta_dac u_dac_l (
    .clock (clock),
    .reset (reset),
    .din   (left),
    .dout  (dac_l)
  );

  sigma_delta_dac u_dac_r (
    .clock (clock),
    .reset (reset),
    .din   (right),
    .dout  (dac_r)
  );

endmodule

// File: tb/tb_turbosound_mixer.sv
// Self-checking bench for turbosound_mixer: directed cases, randomized mixes
// against an arithmetic stereo model, continuous strobing, mid-mix reset and
// sigma-delta bit density over 2048-cycle windows.
module tb_turbosound_mixer;

  logic        clock = 1'b0;
  logic        reset;
  logic        strobe;
  logic [1:0]  mode;
  logic [7:0]  a1, b1, c1, a2, b2, c2;
  logic        busy, valid;
  logic [10:0] left, right;
  logic        dac_l, dac_r;

  int checkCount = 0;
  int failCount  = 0;
  int latency;
  int busyCount;

  turbosound_mixer dut (
    .clock  (clock),
    .reset  (reset),
    .strobe (strobe),
    .mode   (mode),
    .a1     (a1),
    .b1     (b1),
    .c1     (c1),
    .a2     (a2),
    .b2     (b2),
    .c2     (c2),
    .busy   (busy),
    .valid  (valid),
    .left   (left),
    .right  (right),
    .dac_l  (dac_l),
    .dac_r  (dac_r)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference mix: per-side sums of the six levels under the chosen stereo placement.
  function automatic void mixModel(input logic [1:0] m, input logic [47:0] ch,
                                   output int l, output int r);
    int sa, sb, sc;
    sa = int'(ch[47:40]) + int'(ch[23:16]);
    sb = int'(ch[39:32]) + int'(ch[15:8]);
    sc = int'(ch[31:24]) + int'(ch[7:0]);
    case (m)
      2'd0:    begin l = 2 * sa + sb; r = 2 * sc + sb; end
      2'd1:    begin l = 2 * sa + sc; r = 2 * sb + sc; end
      default: begin l = sa + sb + sc; r = sa + sb + sc; end
    endcase
  endfunction

  // Issue one strobe and step until valid, recording latency and busy cycles.
  task automatic applyStimulus(input logic [1:0] m, input logic [47:0] ch);
    mode = m;
    {a1, b1, c1, a2, b2, c2} = ch;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    latency = 0;
    busyCount = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) busyCount++;
      if (valid) break;
      tick();
      latency++;
    end
  endtask

  task automatic mixAndCheck(input string tag, input logic [1:0] m, input logic [47:0] ch);
    int l, r;
    mixModel(m, ch, l, r);
    applyStimulus(m, ch);
    checkOutput({tag, " latency"}, latency, 7);
    checkOutput({tag, " busy"}, busyCount, 7);
    checkOutput({tag, " left"}, int'(left), l);
    checkOutput({tag, " right"}, int'(right), r);
    tick();
    checkOutput({tag, " valid width"}, int'(valid), 0);
  endtask

  initial begin
    int l, r, cyc, pulses, onesL, onesR;
    logic [47:0] ch;
    logic [47:0] dacPatterns [3];

    reset = 1'b1;
    strobe = 1'b0;
    mode = 2'd0;
    {a1, b1, c1, a2, b2, c2} = '0;
    tick();
    tick();
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset valid", int'(valid), 0);
    checkOutput("reset left", int'(left), 0);
    checkOutput("reset right", int'(right), 0);
    checkOutput("reset dac_l", int'(dac_l), 0);
    checkOutput("reset dac_r", int'(dac_r), 0);
    reset = 1'b0;
    tick();

    // Directed mixes.
    mixAndCheck("abc a1", 2'd0, {8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    mixAndCheck("acb b1c2", 2'd1, {8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 8'd40});
    mixAndCheck("abc b1c2", 2'd0, {8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 8'd40});
    mixAndCheck("mono max", 2'd2, {6{8'd255}});
    mixAndCheck("mode3 max", 2'd3, {6{8'd255}});

    // Randomized mixes against the model.
    for (int n = 0; n < 24; n++) begin
      ch = {$urandom, $urandom};
      mixAndCheck("random", 2'($urandom_range(0, 3)), ch);
    end

    // Continuous strobe; a1 changes during the second ACC cycle of the first sample.
    mode = 2'd0;
    {a1, b1, c1, a2, b2, c2} = {8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0};
    strobe = 1'b1;
    tick();
    tick();
    a1 = 8'd200;
    pulses = 0;
    for (cyc = 2; cyc <= 24; cyc++) begin
      tick();
      if (valid) begin
        checkOutput("stream pulse cycle", cyc, 7 + 8 * pulses);
        if (pulses == 0) begin
          checkOutput("stream first left", int'(left), 10);
          checkOutput("stream first right", int'(right), 10);
        end else begin
          checkOutput("stream next left", int'(left), 410);
          checkOutput("stream next right", int'(right), 10);
        end
        pulses++;
      end
    end
    checkOutput("stream pulse count", pulses, 3);
    strobe = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Reset in the middle of ACC aborts the mix.
    mixAndCheck("pre-reset", 2'd0, {8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100});
    mode = 2'd2;
    {a1, b1, c1, a2, b2, c2} = {6{8'd33}};
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort left", int'(left), 0);
    checkOutput("abort right", int'(right), 0);
    checkOutput("abort valid", int'(valid), 0);
    checkOutput("abort dac_l", int'(dac_l), 0);
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid) pulses++;
    end
    checkOutput("abort no valid", pulses, 0);
    mixAndCheck("post-reset", 2'd1, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6});

    // Sigma-delta density over 2048 cycles for held samples 1024, 0 and 1530.
    dacPatterns[0] = {8'd255, 8'd255, 8'd255, 8'd255, 8'd4, 8'd0};
    dacPatterns[1] = '0;
    dacPatterns[2] = {6{8'd255}};
    for (int p = 0; p < 3; p++) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      mixModel(2'd2, dacPatterns[p], l, r);
      mixAndCheck("dac sample", 2'd2, dacPatterns[p]);
      onesL = 0;
      onesR = 0;
      for (int i = 0; i < 2048; i++) begin
        if (dac_l) onesL++;
        if (dac_r) onesR++;
        if (i < 2047) tick();
      end
      checkOutput("dac_l ones", onesL, l);
      checkOutput("dac_r ones", onesR, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
